// File: rtl/ms_digit_scan_display_if.sv
// Digit-stream input and 7-segment pin bundle for ms_digit_scan_display.
// Latency: none; this is wiring only.
// Backpressure: none; digit_valid is a one-cycle strobe and is always accepted.
interface ms_digit_scan_display_if;
    logic [3:0] digit_in;
    logic [1:0] digit_sel;
    logic       digit_valid;
    logic       blank;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_done;

    // Producer side: the reaction timer core or the testbench.
    modport master (
        output digit_in, digit_sel, digit_valid, blank,
        input  seg, dp, an, frame_done
    );

    // Display block side.
    modport slave (
        input  digit_in, digit_sel, digit_valid, blank,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/ms_digit_scan_display.sv
// Rebuilds 4-digit frames from {digit, sel} pairs and scans them onto a common-anode 7-seg display.
// Latency: outputs are registered, 1 cycle after scan_idx/disp; frame_done 1 cycle after the completing digit.
// Backpressure: none; every digit_valid is captured. Optional macro LEADING_ZERO_BLANK_EN darkens leading zeros.
module ms_digit_scan_display #(
    parameter int SCAN_DIV = 50,
    parameter int DP_DIGIT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    ms_digit_scan_display_if.slave    bus
);
    localparam int            CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [3:0][3:0] shadow_q, shadow_d;
    logic [3:0][3:0] disp_q,   disp_d;
    logic [3:0]      rx_mask_q, rx_mask_d;
    logic [CW-1:0]   scan_cnt_q, scan_cnt_d;
    logic [1:0]      scan_idx_q, scan_idx_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [3:0]      an_q, an_d;
    logic            frame_done_q, frame_done_d;

    logic [3:0]      sel_onehot;
    logic            commit;
    logic            scan_wrap;
    logic            lz_dark;

    // Active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [6:0] dec7(input logic [3:0] v);
        case (v)
            4'd0:    dec7 = 7'h40;
            4'd1:    dec7 = 7'h79;
            4'd2:    dec7 = 7'h24;
            4'd3:    dec7 = 7'h30;
            4'd4:    dec7 = 7'h19;
            4'd5:    dec7 = 7'h12;
            4'd6:    dec7 = 7'h02;
            4'd7:    dec7 = 7'h78;
            4'd8:    dec7 = 7'h00;
            4'd9:    dec7 = 7'h10;
            default: dec7 = 7'h3F;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // True when digit idx and every higher digit are zero.
    function automatic logic zero_from(input logic [3:0][3:0] d, input logic [1:0] idx);
        zero_from = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if ((j >= int'(idx)) && (d[j] != 4'd0)) zero_from = 1'b0;
        end
    endfunction
`endif

    // Capture, atomic commit and scan-counter next state.
    always_comb begin
        shadow_d   = shadow_q;
        rx_mask_d  = rx_mask_q;
        disp_d     = disp_q;
        sel_onehot = 4'b0001 << bus.digit_sel;
        commit     = bus.digit_valid && ((rx_mask_q | sel_onehot) == 4'hF);
        if (bus.digit_valid) begin
            shadow_d[bus.digit_sel]  = bus.digit_in;
            rx_mask_d[bus.digit_sel] = 1'b1;
        end
        // shadow_d already holds the incoming digit merged in, so the frame lands whole.
        if (commit) begin
            disp_d    = shadow_d;
            rx_mask_d = 4'h0;
        end
        scan_wrap  = (scan_cnt_q == CNT_MAX);
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        scan_idx_d = scan_wrap ? scan_idx_q + 2'd1 : scan_idx_q;
    end

    // Pin drive for the currently selected digit, with blanking overrides.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        lz_dark = zero_from(disp_q, scan_idx_q) && (scan_idx_q != 2'd0)
                  && (int'(scan_idx_q) != DP_DIGIT);
`else
        lz_dark = 1'b0;
`endif
        an_d         = ~(4'b0001 << scan_idx_q);
        seg_d        = lz_dark ? 7'h7F : dec7(disp_q[scan_idx_q]);
        dp_d         = ~(int'(scan_idx_q) == DP_DIGIT);
        frame_done_d = commit;
        if (bus.blank) begin
            an_d  = 4'hF;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q     <= '0;
            disp_q       <= '0;
            rx_mask_q    <= 4'h0;
            scan_cnt_q   <= '0;
            scan_idx_q   <= 2'd0;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            an_q         <= 4'hF;
            frame_done_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            rx_mask_q    <= rx_mask_d;
            scan_cnt_q   <= scan_cnt_d;
            scan_idx_q   <= scan_idx_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_ms_digit_scan_display.sv
// Bench for ms_digit_scan_display: directed frames, reset, overwrite and blank cases, then random traffic.
// Latency: each clock edge is compared 1 time unit later against a cycle-level reference model.
// Backpressure: none.
module tb_ms_digit_scan_display;
    localparam int SCAN_DIV = 50;
    localparam int DP_DIGIT = 3;

    logic clk;
    logic rst;
    ms_digit_scan_display_if dif ();

    ms_digit_scan_display #(.SCAN_DIV(SCAN_DIV), .DP_DIGIT(DP_DIGIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: displayed frame, pending shadow digits, which positions have arrived,
    // and the number of clock edges since reset was released.
    int       m_disp [4];
    int       m_sh   [4];
    bit       m_got  [4];
    int       m_edges;
    logic [6:0] dec_tab [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
    endtask

    function automatic bit lz_dark(input int idx);
        bit dark;
        dark = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        dark = (idx != 0) && (idx != DP_DIGIT);
        for (int j = idx; j < 4; j++) if (m_disp[j] != 0) dark = 1'b0;
`endif
        return dark;
    endfunction

    // Advance one clock, update the model from the inputs present at the edge, and compare pins.
    task automatic tick();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_fd;
        int         idx;
        bit         all;
        @(posedge clk);
        e_fd = 1'b0;
        if (rst) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            for (int i = 0; i < 4; i++) begin
                m_disp[i] = 0; m_sh[i] = 0; m_got[i] = 1'b0;
            end
            m_edges = 0;
        end else begin
            idx = (m_edges / SCAN_DIV) % 4;
            if (dif.blank) begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an  = ~(4'(1) << idx);
                e_seg = lz_dark(idx) ? 7'h7F : dec_tab[m_disp[idx]];
                e_dp  = (idx == DP_DIGIT) ? 1'b0 : 1'b1;
            end
            if (dif.digit_valid) begin
                m_sh[dif.digit_sel]  = int'(dif.digit_in);
                m_got[dif.digit_sel] = 1'b1;
                all = m_got[0] && m_got[1] && m_got[2] && m_got[3];
                if (all) begin
                    for (int i = 0; i < 4; i++) begin
                        m_disp[i] = m_sh[i]; m_got[i] = 1'b0;
                    end
                    e_fd = 1'b1;
                end
            end
            m_edges++;
        end
        #1;
        chk("an",         32'(dif.an),         32'(e_an));
        chk("seg",        32'(dif.seg),        32'(e_seg));
        chk("dp",         32'(dif.dp),         32'(e_dp));
        chk("frame_done", 32'(dif.frame_done), 32'(e_fd));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input int d, input int s);
        dif.digit_valid = 1'b1;
        dif.digit_in    = 4'(d);
        dif.digit_sel   = 2'(s);
        tick();
        dif.digit_valid = 1'b0;
    endtask

    initial begin
        dec_tab[0] = 7'h40; dec_tab[1] = 7'h79; dec_tab[2] = 7'h24; dec_tab[3] = 7'h30;
        dec_tab[4] = 7'h19; dec_tab[5] = 7'h12; dec_tab[6] = 7'h02; dec_tab[7] = 7'h78;
        dec_tab[8] = 7'h00; dec_tab[9] = 7'h10;
        for (int i = 10; i < 16; i++) dec_tab[i] = 7'h3F;
        for (int i = 0; i < 4; i++) begin
            m_disp[i] = 0; m_sh[i] = 0; m_got[i] = 1'b0;
        end
        m_edges = 0;

        rst = 1'b1;
        dif.digit_valid = 1'b0;
        dif.digit_in    = 4'd0;
        dif.digit_sel   = 2'd0;
        dif.blank       = 1'b0;

        // Reset held, then a full refresh so the anode walk is seen.
        idle(3);
        rst = 1'b0;
        idle(4 * SCAN_DIV + 10);

        // Back-to-back frame 0,2,3,7 (thousands..ones).
        send(3, 1); send(2, 2); send(0, 3); send(7, 0);
        idle(4 * SCAN_DIV + 5);

        // Partial frame discarded by reset; a lone sel3 must not commit.
        send(9, 0); send(9, 1); send(9, 2);
        rst = 1'b1; idle(2); rst = 1'b0;
        send(9, 3);
        idle(4 * SCAN_DIV);

        // Overwrite of the ones digit before commit.
        send(5, 0); send(6, 0); send(1, 1); send(1, 2); send(1, 3);
        idle(4 * SCAN_DIV);

        // Frame 1234 then a 120-cycle blank window.
        send(4, 0); send(3, 1); send(2, 2); send(1, 3);
        idle(SCAN_DIV + 7);
        dif.blank = 1'b1; idle(120); dif.blank = 1'b0;
        idle(2 * SCAN_DIV);

        // Leading-zero frame 0045, including a commit landing on a scan wrap.
        idle((SCAN_DIV - 4) - (m_edges % SCAN_DIV));
        send(5, 0); send(4, 1); send(0, 2); send(0, 3);
        idle(4 * SCAN_DIV);

        // Random traffic with occasional blanks and resets.
        for (int c = 0; c < 4000; c++) begin
            dif.digit_valid = ($urandom_range(0, 3) == 0);
            dif.digit_sel   = 2'($urandom_range(0, 3));
            dif.digit_in    = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) dif.blank = ~dif.blank;
            rst = ($urandom_range(0, 799) == 0);
            tick();
        end
        dif.digit_valid = 1'b0;
        dif.blank       = 1'b0;
        rst             = 1'b0;
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
